mem_line_engine: RTL and testbench
==================================

MEM_LINE_ENGINE -- requirements
Module: mem_line_engine

Interface
REQ-001 SHALL have parameter WORD_W, default 32: AXI data-beat width in bits.
REQ-002 SHALL have parameter BEATS, default 16: beats per cache line, a power of two; the line is WORD_W*BEATS bits, 64 B at the defaults.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 valid_wb  in  1  controller requests a dirty-line writeback.
REQ-006 ready_wb  out  1  one-cycle pulse: writeback complete.
REQ-007 ready_ld  in  1  controller requests a line fill.
REQ-008 valid_ld  out  1  one-cycle pulse: ld_line holds the fetched line.
REQ-009 addr  in  32  line address, sampled at request accept.
REQ-010 wb_line  in  WORD_W*BEATS  victim line, sampled at writeback accept.
REQ-011 ld_line  out  WORD_W*BEATS  fetched line; word i at bits [i*WORD_W +: WORD_W].
REQ-012 awvalid/awready  out/in  1/1  AXI write-address handshake.
REQ-013 awaddr  out  32  write burst address.
REQ-014 awlen  out  8  constant BEATS-1; the burst type is INCR.
REQ-015 wvalid/wready  out/in  1/1  AXI write-data handshake.
REQ-016 wdata  out  WORD_W  write beat data.
REQ-017 wlast  out  1  final write beat.
REQ-018 bvalid/bready  in/out  1/1  AXI write-response handshake; bresp is not used.
REQ-019 arvalid/arready  out/in  1/1  AXI read-address handshake.
REQ-020 araddr  out  32  read burst address.
REQ-021 arlen  out  8  constant BEATS-1.
REQ-022 rvalid/rready  in/out  1/1  AXI read-data handshake; rlast and rresp are not used.
REQ-023 rdata  in  WORD_W  read beat data.

Function
REQ-024 SHALL implement an FSM with states IDLE, AW, W, B, WACK, AR, R and RACK.
REQ-025 In IDLE, valid_wb SHALL take priority: it goes to AW and captures wb_line and addr; otherwise ready_ld goes to AR and captures addr.
REQ-026 If valid_wb and ready_ld are both high in IDLE, the engine SHALL complete the writeback before starting the load.
REQ-027 awaddr and araddr SHALL equal the captured addr with its low log2(WORD_W*BEATS/8) bits cleared; for example, 0x1234 becomes 0x1200.
REQ-028 AW: awvalid SHALL be 1 with a stable awaddr until awready; on awvalid&awready the FSM goes to W and clears the beat counter.
REQ-029 W: wvalid=1 and wdata = captured word[cnt], starting at word 0; cnt SHALL increment only on wvalid&wready.
REQ-030 wlast SHALL be 1 iff cnt==BEATS-1; on the last handshake the FSM goes to B.
REQ-031 While wready=0, wdata, wlast and cnt SHALL hold.
REQ-032 B: bready=1; on bvalid the FSM goes to WACK.
REQ-033 WACK: ready_wb=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-034 AR: arvalid=1 until arready, then the FSM goes to R with cnt cleared.
REQ-035 R: rready=1; on each rvalid, rdata SHALL be written to ld_line word[cnt] and cnt incremented.
REQ-036 After BEATS read beats the FSM SHALL go to RACK.
REQ-037 RACK: valid_ld=1 for exactly one cycle, then the FSM returns to IDLE.
REQ-038 ld_line SHALL be complete in the RACK cycle and SHALL hold until the next fill writes it.
REQ-039 cnt SHALL be log2(BEATS) bits wide and wrap to 0 after the final beat.
REQ-040 Once a transaction is accepted, request deassertion SHALL NOT abort it; only rst aborts.
REQ-041 All outputs SHALL be driven from registers or a decode of the state register only, with no combinational path from input to output.
REQ-042 With zero-wait memory, a writeback SHALL take BEATS+3 cycles from accept to the ready_wb pulse, and a load SHALL take BEATS+2 cycles from accept to the valid_ld pulse.

Reset
REQ-043 While rst=1, FSM=IDLE and cnt=0.
REQ-044 While rst=1, all valid/ready/last outputs SHALL be 0, and captured data and ld_line SHALL be 0.
REQ-045 rst asserted mid-burst SHALL take effect immediately; after release the engine SHALL stay in IDLE until a new request arrives.

Verification
REQ-046 Writeback: addr=0x1234, wb_line word i = 0xA0+i, memory always ready -> awaddr=0x1200, awlen=15, wdata 0xA0..0xAF, wlast only on 0xAF, one ready_wb pulse.
REQ-047 W backpressure: wready=0 for 5 cycles at cnt=3 -> wvalid stays 1 and wdata stays 0xA3; the burst still totals 16 beats.
REQ-048 Load: ready_ld, addr=0x40, rdata=0x100+i, rvalid toggling every cycle -> araddr=0x40, ld_line word i = 0x100+i, one valid_ld pulse.
REQ-049 valid_wb and ready_ld asserted together -> awvalid first; arvalid only after ready_wb pulses.
REQ-050 rst pulse at W beat 7 -> wvalid=0 at once; after release no awvalid or arvalid appears without a new request.
REQ-051 Controller sequence WB then LD: valid_wb drops after ready_wb and ready_ld rises -> exactly one write burst, then exactly one read burst.

Source files
------------

// File: rtl/mem_line_engine_if.sv
// AXI-style memory port used by mem_line_engine: write address/data/response
// and read address/data channels. The engine is the master, memory the slave.
interface mem_line_engine_if #(
   parameter int WORD_W = 32
);
   logic              awvalid;
   logic              awready;
   logic [31:0]       awaddr;
   logic [7:0]        awlen;
   logic              wvalid;
   logic              wready;
   logic [WORD_W-1:0] wdata;
   logic              wlast;
   logic              bvalid;
   logic              bready;
   logic              arvalid;
   logic              arready;
   logic [31:0]       araddr;
   logic [7:0]        arlen;
   logic              rvalid;
   logic              rready;
   logic [WORD_W-1:0] rdata;

   modport master (
      output awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
             arvalid, araddr, arlen, rready,
      input  awready, wready, bvalid, arready, rvalid, rdata
   );

   modport slave (
      input  awvalid, awaddr, awlen, wvalid, wdata, wlast, bready,
             arvalid, araddr, arlen, rready,
      output awready, wready, bvalid, arready, rvalid, rdata
   );
endinterface

// File: rtl/mem_line_engine.sv
// mem_line_engine: moves one cache line between a cache controller and an
// AXI memory port. Writebacks go out as one INCR write burst, fills come in
// as one INCR read burst; one transaction is in flight at a time and
// writebacks win over fills when both are requested together.
module mem_line_engine #(
   parameter int WORD_W = 32,
   parameter int BEATS  = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    valid_wb,
   output logic                    ready_wb,
   input  logic                    ready_ld,
   output logic                    valid_ld,
   input  logic [31:0]             addr,
   input  logic [WORD_W*BEATS-1:0] wb_line,
   output logic [WORD_W*BEATS-1:0] ld_line,
   mem_line_engine_if.master       axi
);

   localparam int               LINE_W    = WORD_W * BEATS;
   localparam int               CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
   localparam logic [CNT_W-1:0] LAST      = CNT_W'(BEATS - 1);
   // Bursts always start on a line boundary: drop the byte offset within a line.
   localparam logic [31:0]      ADDR_MASK = ~(32'(LINE_W / 8) - 32'd1);

   typedef enum logic [2:0] {
      IDLE, AW, W, B, WACK, AR, R, RACK
   } state_t;

   state_t            state_q;
   logic [CNT_W-1:0]  cnt_q;
   logic [31:0]       addr_q;
   logic [LINE_W-1:0] line_q;
   logic [LINE_W-1:0] ld_line_q;
   logic              awvalid_q;
   logic              wvalid_q;
   logic              wlast_q;
   logic              bready_q;
   logic              arvalid_q;
   logic              rready_q;
   logic              ready_wb_q;
   logic              valid_ld_q;

   // Transaction sequencer: every output flag is set on the edge that enters
   // the state owning it, so outputs never depend combinationally on inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         // NOTE: the wide line registers are reset too, so nothing left over
         // from an aborted transaction can be observed after rst.
         line_q     <= '0;
         ld_line_q  <= '0;
         awvalid_q  <= 1'b0;
         wvalid_q   <= 1'b0;
         wlast_q    <= 1'b0;
         bready_q   <= 1'b0;
         arvalid_q  <= 1'b0;
         rready_q   <= 1'b0;
         ready_wb_q <= 1'b0;
         valid_ld_q <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments throughout, so every branch below
         // reads the pre-edge values and the two default pulses can be
         // overridden later in the same block.
         ready_wb_q <= 1'b0;
         valid_ld_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (valid_wb) begin
                  addr_q    <= addr & ADDR_MASK;
                  line_q    <= wb_line;
                  awvalid_q <= 1'b1;
                  state_q   <= AW;
               end else if (ready_ld) begin
                  addr_q    <= addr & ADDR_MASK;
                  arvalid_q <= 1'b1;
                  state_q   <= AR;
               end
            end
            AW: begin
               if (axi.awready) begin
                  awvalid_q <= 1'b0;
                  wvalid_q  <= 1'b1;
                  wlast_q   <= (LAST == '0);
                  cnt_q     <= '0;
                  state_q   <= W;
               end
            end
            W: begin
               if (axi.wready) begin
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST) begin
                     wvalid_q <= 1'b0;
                     wlast_q  <= 1'b0;
                     bready_q <= 1'b1;
                     state_q  <= B;
                  end else begin
                     wlast_q <= ((cnt_q + 1'b1) == LAST);
                  end
               end
            end
            B: begin
               if (axi.bvalid) begin
                  bready_q   <= 1'b0;
                  ready_wb_q <= 1'b1;
                  state_q    <= WACK;
               end
            end
            WACK: state_q <= IDLE;
            AR: begin
               if (axi.arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  cnt_q     <= '0;
                  state_q   <= R;
               end
            end
            R: begin
               if (axi.rvalid) begin
                  ld_line_q[cnt_q*WORD_W +: WORD_W] <= axi.rdata;
                  cnt_q <= cnt_q + 1'b1;
                  if (cnt_q == LAST) begin
                     rready_q   <= 1'b0;
                     valid_ld_q <= 1'b1;
                     state_q    <= RACK;
                  end
               end
            end
            RACK:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   assign ready_wb    = ready_wb_q;
   assign valid_ld    = valid_ld_q;
   assign ld_line     = ld_line_q;

   assign axi.awvalid = awvalid_q;
   assign axi.awaddr  = addr_q;
   assign axi.awlen   = 8'(BEATS - 1);
   assign axi.wvalid  = wvalid_q;
   // Beat data is a register select by the beat counter; it holds while
   // wready is low because cnt_q only moves on a handshake.
   assign axi.wdata   = line_q[cnt_q*WORD_W +: WORD_W];
   assign axi.wlast   = wlast_q;
   assign axi.bready  = bready_q;
   assign axi.arvalid = arvalid_q;
   assign axi.araddr  = addr_q;
   assign axi.arlen   = 8'(BEATS - 1);
   assign axi.rready  = rready_q;

endmodule

// File: tb/tb_mem_line_engine.sv
// Bench for mem_line_engine: a transaction-level reference model tracks which
// bus handshakes are still owed and checks every DUT output each cycle;
// directed scenarios pin the model with hand-computed literals, followed by a
// randomized run with random memory readiness and occasional resets.
module tb_mem_line_engine;
   localparam int          WORD_W    = 32;
   localparam int          BEATS     = 16;
   localparam int          LINE_W    = WORD_W * BEATS;
   localparam logic [31:0] LINE_MASK = ~32'(LINE_W / 8 - 1);

   logic              clk      = 1'b0;
   logic              rst      = 1'b1;
   logic              valid_wb = 1'b0;
   logic              ready_ld = 1'b0;
   logic [31:0]       addr     = '0;
   logic [LINE_W-1:0] wb_line  = '0;
   logic              ready_wb;
   logic              valid_ld;
   logic [LINE_W-1:0] ld_line;

   mem_line_engine_if #(.WORD_W(WORD_W)) axi_if ();

   mem_line_engine #(.WORD_W(WORD_W), .BEATS(BEATS)) dut (
      .clk      (clk),
      .rst      (rst),
      .valid_wb (valid_wb),
      .ready_wb (ready_wb),
      .ready_ld (ready_ld),
      .valid_ld (valid_ld),
      .addr     (addr),
      .wb_line  (wb_line),
      .ld_line  (ld_line),
      .axi      (axi_if.master)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [LINE_W-1:0] act,
                        input logic [LINE_W-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- reference model ----------------
   typedef enum int {OP_NONE, OP_WB, OP_LD} op_t;
   op_t               m_op      = OP_NONE;
   bit                m_aw_done = 1'b0;
   bit                m_b_done  = 1'b0;
   bit                m_ar_done = 1'b0;
   int                m_wbeats  = 0;
   int                m_rbeats  = 0;
   logic [31:0]       m_addr    = '0;
   logic [LINE_W-1:0] m_line    = '0;
   logic [LINE_W-1:0] m_ld      = '0;

   logic e_awvalid, e_wvalid, e_bready, e_ready_wb;
   logic e_arvalid, e_rready, e_valid_ld;
   assign e_awvalid  = (m_op == OP_WB) && !m_aw_done;
   assign e_wvalid   = (m_op == OP_WB) && m_aw_done && (m_wbeats < BEATS);
   assign e_bready   = (m_op == OP_WB) && (m_wbeats == BEATS) && !m_b_done;
   assign e_ready_wb = (m_op == OP_WB) && m_b_done;
   assign e_arvalid  = (m_op == OP_LD) && !m_ar_done;
   assign e_rready   = (m_op == OP_LD) && m_ar_done && (m_rbeats < BEATS);
   assign e_valid_ld = (m_op == OP_LD) && (m_rbeats == BEATS);

   // Model: one transaction at a time, advanced by each owed handshake.
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_op <= OP_NONE; m_aw_done <= 1'b0; m_b_done <= 1'b0; m_ar_done <= 1'b0;
         m_wbeats <= 0; m_rbeats <= 0; m_addr <= '0; m_line <= '0; m_ld <= '0;
      end else begin
         case (m_op)
            OP_NONE: begin
               m_aw_done <= 1'b0; m_b_done <= 1'b0; m_ar_done <= 1'b0;
               m_wbeats <= 0; m_rbeats <= 0;
               if (valid_wb) begin
                  m_op <= OP_WB; m_addr <= addr & LINE_MASK; m_line <= wb_line;
               end else if (ready_ld) begin
                  m_op <= OP_LD; m_addr <= addr & LINE_MASK;
               end
            end
            OP_WB: begin
               if (e_ready_wb)                         m_op <= OP_NONE;
               else if (e_awvalid && axi_if.awready)   m_aw_done <= 1'b1;
               else if (e_wvalid && axi_if.wready)     m_wbeats <= m_wbeats + 1;
               else if (e_bready && axi_if.bvalid)     m_b_done <= 1'b1;
            end
            default: begin
               if (e_valid_ld)                         m_op <= OP_NONE;
               else if (e_arvalid && axi_if.arready)   m_ar_done <= 1'b1;
               else if (e_rready && axi_if.rvalid) begin
                  m_ld[m_rbeats*WORD_W +: WORD_W] <= axi_if.rdata;
                  m_rbeats <= m_rbeats + 1;
               end
            end
         endcase
      end
   end

   // ---------------- memory slave ----------------
   int          rdy_pct    = 100;
   bit          r_toggle   = 1'b0;
   bit          rd_random  = 1'b0;
   logic [31:0] rd_base    = 32'h100;
   int          stall_at   = -1;
   int          stall_left = 0;

   // Slave drive, 2 time units after each rising edge.
   always @(posedge clk) begin
      #2;
      axi_if.awready = (int'($urandom_range(99)) < rdy_pct);
      axi_if.wready  = (int'($urandom_range(99)) < rdy_pct);
      axi_if.bvalid  = (int'($urandom_range(99)) < rdy_pct);
      axi_if.arready = (int'($urandom_range(99)) < rdy_pct);
      axi_if.rvalid  = r_toggle ? !axi_if.rvalid : (int'($urandom_range(99)) < rdy_pct);
      axi_if.rdata   = rd_random ? $urandom : rd_base + 32'(m_rbeats);
      if (stall_left > 0 && e_wvalid && m_wbeats == stall_at) begin
         axi_if.wready = 1'b0;
         stall_left--;
      end
   end

   // ---------------- compare and monitor ----------------
   int          cyc = 0;
   int          aw_hs, w_hs, ar_hs, r_hs, wlast_hs, wb_pulses, ld_pulses;
   int          stall_cyc, stall_bad, aw_cyc, ar_cyc, wb_pulse_cyc, first_ar_cyc;
   logic [31:0] first_awaddr, first_araddr, wlast_data;
   logic [7:0]  seen_awlen;

   task automatic clear_mon();
      aw_hs = 0; w_hs = 0; ar_hs = 0; r_hs = 0; wlast_hs = 0; wb_pulses = 0;
      ld_pulses = 0; stall_cyc = 0; stall_bad = 0; aw_cyc = 0; ar_cyc = 0;
      wb_pulse_cyc = -1; first_ar_cyc = -1;
      first_awaddr = '0; first_araddr = '0; wlast_data = '0; seen_awlen = '0;
   endtask

   // Every cycle: DUT outputs against the model, then scenario counters.
   always @(negedge clk) begin
      cyc++;
      check("awvalid",  axi_if.awvalid, e_awvalid);
      check("wvalid",   axi_if.wvalid,  e_wvalid);
      check("bready",   axi_if.bready,  e_bready);
      check("ready_wb", ready_wb,       e_ready_wb);
      check("arvalid",  axi_if.arvalid, e_arvalid);
      check("rready",   axi_if.rready,  e_rready);
      check("valid_ld", valid_ld,       e_valid_ld);
      check("ld_line",  ld_line,        m_ld);
      check("awlen",    axi_if.awlen,   8'(BEATS - 1));
      check("arlen",    axi_if.arlen,   8'(BEATS - 1));
      if (e_awvalid) check("awaddr", axi_if.awaddr, m_addr);
      if (e_arvalid) check("araddr", axi_if.araddr, m_addr);
      if (e_wvalid) begin
         check("wdata", axi_if.wdata, m_line[m_wbeats*WORD_W +: WORD_W]);
         check("wlast", axi_if.wlast, (m_wbeats == BEATS - 1));
      end

      if (axi_if.awvalid) aw_cyc++;
      if (axi_if.arvalid) begin
         ar_cyc++;
         if (first_ar_cyc < 0) first_ar_cyc = cyc;
      end
      if (axi_if.awvalid && axi_if.awready) begin
         if (aw_hs == 0) begin first_awaddr = axi_if.awaddr; seen_awlen = axi_if.awlen; end
         aw_hs++;
      end
      if (axi_if.arvalid && axi_if.arready) begin
         if (ar_hs == 0) first_araddr = axi_if.araddr;
         ar_hs++;
      end
      if (axi_if.wvalid && axi_if.wready) begin
         w_hs++;
         if (axi_if.wlast) begin wlast_hs++; wlast_data = axi_if.wdata; end
      end
      if (axi_if.wvalid && !axi_if.wready) begin
         stall_cyc++;
         if (axi_if.wdata !== 32'hA3) stall_bad++;
      end
      if (axi_if.rvalid && axi_if.rready) r_hs++;
      if (ready_wb) begin
         wb_pulses++;
         if (wb_pulse_cyc < 0) wb_pulse_cyc = cyc;
      end
      if (valid_ld) ld_pulses++;
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic wait_pulse(input bit want_wb, output int lat);
      bit done;
      done = 1'b0;
      lat  = 0;
      for (int i = 0; i < 400 && !done; i++) begin
         step();
         lat++;
         if (want_wb ? ready_wb : valid_ld) done = 1'b1;
      end
      check(want_wb ? "wb_done" : "ld_done", done, 1'b1);
   endtask

   task automatic fill_line(input logic [31:0] base);
      for (int i = 0; i < BEATS; i++) wb_line[i*WORD_W +: WORD_W] = base + 32'(i);
   endtask

   initial begin
      int                lat;
      bit                found;
      logic [LINE_W-1:0] exp_ld;

      axi_if.awready = 1'b0; axi_if.wready = 1'b0; axi_if.bvalid = 1'b0;
      axi_if.arready = 1'b0; axi_if.rvalid = 1'b0; axi_if.rdata  = '0;
      clear_mon();

      // Reset values.
      repeat (3) step();
      check("rst_ready_wb", ready_wb,       1'b0);
      check("rst_valid_ld", valid_ld,       1'b0);
      check("rst_awvalid",  axi_if.awvalid, 1'b0);
      check("rst_wlast",    axi_if.wlast,   1'b0);
      check("rst_ld_line",  ld_line,        '0);
      rst = 1'b0;
      repeat (2) step();

      // Zero-wait writeback of 0xA0+i at 0x1234.
      clear_mon();
      fill_line(32'hA0); addr = 32'h1234; valid_wb = 1'b1;
      wait_pulse(1'b1, lat);
      valid_wb = 1'b0;
      repeat (3) step();
      check("wb_latency",  lat,          BEATS + 3);
      check("wb_awaddr",   first_awaddr, 32'h1200);
      check("wb_awlen",    seen_awlen,   8'd15);
      check("wb_aw_hs",    aw_hs,        1);
      check("wb_w_hs",     w_hs,         16);
      check("wb_wlast_hs", wlast_hs,     1);
      check("wb_wlast_d",  wlast_data,   32'hAF);
      check("wb_pulses",   wb_pulses,    1);

      // Writeback with 5 stalled cycles at beat 3; request dropped after accept.
      clear_mon();
      fill_line(32'hA0); addr = 32'h1234; valid_wb = 1'b1;
      stall_at = 3; stall_left = 5;
      step();
      valid_wb = 1'b0; addr = 32'hFFFF_FFFF; fill_line(32'h5555_0000);
      wait_pulse(1'b1, lat);
      repeat (3) step();
      stall_at = -1;
      check("bp_latency",  lat + 1,      BEATS + 3 + 5);
      check("bp_stalls",   stall_cyc,    5);
      check("bp_stall_d",  stall_bad,    0);
      check("bp_w_hs",     w_hs,         16);
      check("bp_awaddr",   first_awaddr, 32'h1200);
      check("bp_pulses",   wb_pulses,    1);

      // Zero-wait load at 0x40.
      clear_mon();
      rd_base = 32'h200; addr = 32'h40; ready_ld = 1'b1;
      wait_pulse(1'b0, lat);
      ready_ld = 1'b0;
      repeat (3) step();
      for (int i = 0; i < BEATS; i++) exp_ld[i*WORD_W +: WORD_W] = 32'h200 + 32'(i);
      check("ld_latency", lat,          BEATS + 2);
      check("ld_araddr",  first_araddr, 32'h40);
      check("ld_line_zw", ld_line,      exp_ld);

      // Load with rvalid toggling every cycle.
      clear_mon();
      rd_base = 32'h100; r_toggle = 1'b1; addr = 32'h40; ready_ld = 1'b1;
      wait_pulse(1'b0, lat);
      ready_ld = 1'b0;
      repeat (3) step();
      r_toggle = 1'b0;
      for (int i = 0; i < BEATS; i++) exp_ld[i*WORD_W +: WORD_W] = 32'h100 + 32'(i);
      check("ldt_line",   ld_line,      exp_ld);
      check("ldt_r_hs",   r_hs,         16);
      check("ldt_ar_hs",  ar_hs,        1);
      check("ldt_araddr", first_araddr, 32'h40);
      check("ldt_pulses", ld_pulses,    1);

      // Both requests together: writeback first, fill after ready_wb.
      clear_mon();
      rd_base = 32'h300; fill_line(32'hB0); addr = 32'h80;
      valid_wb = 1'b1; ready_ld = 1'b1;
      wait_pulse(1'b1, lat);
      valid_wb = 1'b0;
      wait_pulse(1'b0, lat);
      ready_ld = 1'b0;
      repeat (3) step();
      check("both_order", (first_ar_cyc > wb_pulse_cyc) && (wb_pulse_cyc > 0), 1'b1);
      check("both_aw_hs", aw_hs, 1);
      check("both_ar_hs", ar_hs, 1);

      // Controller sequence: writeback, then fill raised as ready_wb pulses.
      clear_mon();
      fill_line(32'hC0); addr = 32'h1000; valid_wb = 1'b1;
      wait_pulse(1'b1, lat);
      valid_wb = 1'b0; addr = 32'h2000; ready_ld = 1'b1;
      wait_pulse(1'b0, lat);
      ready_ld = 1'b0;
      repeat (4) step();
      check("seq_aw_hs",  aw_hs,        1);
      check("seq_ar_hs",  ar_hs,        1);
      check("seq_w_hs",   w_hs,         16);
      check("seq_r_hs",   r_hs,         16);
      check("seq_awaddr", first_awaddr, 32'h1000);
      check("seq_araddr", first_araddr, 32'h2000);

      // Reset pulse at write beat 7, then quiet bus without a new request.
      fill_line(32'hA0); addr = 32'h1234; valid_wb = 1'b1;
      step();
      valid_wb = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (e_wvalid && m_wbeats == 7) found = 1'b1;
         else step();
      end
      check("rb_found_beat7", found, 1'b1);
      #1 rst = 1'b1;
      #1;
      check("rb_wvalid_now", axi_if.wvalid,  1'b0);
      check("rb_wlast_now",  axi_if.wlast,   1'b0);
      check("rb_ld_line",    ld_line,        '0);
      repeat (2) step();
      rst = 1'b0;
      clear_mon();
      repeat (20) step();
      check("rb_no_aw", aw_cyc, 0);
      check("rb_no_ar", ar_cyc, 0);

      // Randomized traffic against the model.
      rdy_pct = 60; rd_random = 1'b1;
      for (int n = 0; n < 3000; n++) begin
         valid_wb = ($urandom_range(3) == 0);
         ready_ld = ($urandom_range(3) == 0);
         addr     = $urandom;
         for (int i = 0; i < BEATS; i++) wb_line[i*WORD_W +: WORD_W] = $urandom;
         rst = ($urandom_range(499) == 0);
         step();
      end
      rst = 1'b0; valid_wb = 1'b0; ready_ld = 1'b0;
      repeat (60) step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
